// File: rtl/sized_data_ram_pkg.sv
// sized_data_ram_pkg: shared access-size/state types and the size-to-byte-count helper
package sized_data_ram_pkg;
    localparam int BYTE = 8;

    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_DOUBLE} size_t;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    function automatic logic [3:0] size_to_bytes(input size_t size);
        return 4'd1 << size;
    endfunction
endpackage

// File: rtl/sized_data_ram_lane_format.sv
// ram_lane_format: right-justifies an MSB-first byte window and zero/sign-extends it to the bus width
module ram_lane_format
    import sized_data_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] i_raw,
    input  size_t                 i_size,
    input  logic                  i_signed,
    output logic [DATA_WIDTH-1:0] o_data
);
    localparam int IW = $clog2(DATA_WIDTH);

    logic [3:0]            w_nbytes;
    logic [DATA_WIDTH-1:0] w_just;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_sign;

    // drop the unused trailing bytes, then fill the upper bits with the value's top bit when signed
    always_comb begin
        w_nbytes = size_to_bytes(i_size);
        w_just   = i_raw >> (BYTE * (8 - int'(w_nbytes)));
        w_ext    = {DATA_WIDTH{1'b1}} << (BYTE * int'(w_nbytes));
        w_sign   = i_signed & w_just[IW'(BYTE * int'(w_nbytes) - 1)];
        o_data   = w_sign ? (w_just | w_ext) : w_just;
    end
endmodule

// File: rtl/sized_data_ram.sv
// sized_data_ram: big-endian byte-addressed data RAM with sized loads/stores; define MISALIGN_TRAP_EN to flag misaligned accesses
module sized_data_ram
    import sized_data_ram_pkg::*;
#(
    parameter int ADDRESS_SIZE   = 11,
    parameter int DATA_WIDTH     = 64,
    parameter int ACCESS_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDRESS_SIZE-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_error
);
    localparam int CNT_W = 3;

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    r_write, r_signed, r_error;
    size_t                   r_size;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
    logic [7:0]              r_mem [2**ADDRESS_SIZE];

    logic                    w_fire, w_commit, w_range_err, w_misalign, w_err;
    logic [3:0]              w_nbytes;
    logic [ADDRESS_SIZE:0]   w_last;
    logic [DATA_WIDTH-1:0]   w_raw, w_load, w_left;

    assign req_ready   = r_state == ST_IDLE;
    assign resp_valid  = r_state == ST_RESP;
    assign resp_rdata  = r_rdata;
    assign resp_error  = r_error;
    assign w_fire      = req_valid & req_ready;
    assign w_nbytes    = size_to_bytes(r_size);
    assign w_last      = {1'b0, r_addr} + (ADDRESS_SIZE+1)'(w_nbytes - 4'd1);
    assign w_range_err = w_last[ADDRESS_SIZE];
`ifdef MISALIGN_TRAP_EN
    assign w_misalign  = (r_addr & ADDRESS_SIZE'(w_nbytes - 4'd1)) != '0;
`else
    assign w_misalign  = 1'b0;
`endif
    assign w_err       = w_range_err | w_misalign;
    assign w_left      = r_wdata << (BYTE * (8 - int'(w_nbytes)));

    // next state: accept in IDLE, count down in BUSY, perform the access as BUSY hands over to RESP
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_fire) begin
                w_state_nxt = ST_BUSY;
                w_cnt_nxt   = CNT_W'(ACCESS_LATENCY - 1);
            end
            ST_BUSY: if (r_cnt == '0) begin
                w_state_nxt = ST_RESP;
                w_commit    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
            ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // state, counter, latched request and the held response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= SIZE_BYTE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_fire) begin
                r_write  <= req_write;
                r_signed <= req_signed;
                r_size   <= size_t'(req_size);
                r_addr   <= req_address;
                r_wdata  <= req_wdata;
            end
            if (w_commit) begin
                r_rdata <= (r_write || w_err) ? '0 : w_load;
                r_error <= w_err;
            end
        end
    end

    // store commit: the first address gets the most significant of the N bytes; memory keeps its contents across reset
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_err) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(w_nbytes)) r_mem[r_addr + ADDRESS_SIZE'(k)] <= w_left[DATA_WIDTH-1-BYTE*k -: BYTE];
            end
        end
    end

    // eight-byte window starting at the access address, first byte in the top lane
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < 8; k++) w_raw[DATA_WIDTH-1-BYTE*k -: BYTE] = r_mem[r_addr + ADDRESS_SIZE'(k)];
    end

    ram_lane_format #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
        .i_raw    (w_raw),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_load)
    );
endmodule

// File: tb/tb_sized_data_ram.sv
// tb_sized_data_ram: directed test of sized_data_ram against a byte-array reference model
module tb_sized_data_ram;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [10:0] req_address = 11'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_rdata;
    logic        resp_error;

    int checks = 0;
    int failures = 0;

    sized_data_ram #(.ADDRESS_SIZE(11), .DATA_WIDTH(64), .ACCESS_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // reference model: a plain byte array plus the pending transaction
    logic [7:0]  m_mem [2048];
    logic        m_on = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_valid = 1'b0;
    int          m_left = 0;
    logic        m_wr, m_sg;
    logic [1:0]  m_size;
    int          m_addr;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata = 64'd0;
    logic        m_err = 1'b0;

    task automatic model_commit();
        int n;
        logic [63:0] v;
        n = 1 << m_size;
        m_err = (m_addr + n - 1) > 2047;
`ifdef MISALIGN_TRAP_EN
        if (m_addr % n != 0) m_err = 1'b1;
`endif
        m_rdata = 64'd0;
        if (!m_err) begin
            if (m_wr) begin
                for (int k = 0; k < n; k++) m_mem[m_addr + k] = 8'(m_wdata >> (8 * (n - 1 - k)));
            end else begin
                v = 64'd0;
                for (int k = 0; k < n; k++) v = (v << 8) | 64'(m_mem[m_addr + k]);
                if (m_sg && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
                m_rdata = v;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = 1'b0;
            m_valid = 1'b0;
        end else if (m_valid && resp_ready) begin
            m_pend  = 1'b0;
            m_valid = 1'b0;
        end else if (!m_pend && req_valid) begin
            m_pend  = 1'b1;
            m_left  = LAT;
            m_wr    = req_write;
            m_sg    = req_signed;
            m_size  = req_size;
            m_addr  = int'(req_address);
            m_wdata = req_wdata;
        end else if (m_pend && !m_valid) begin
            m_left--;
            if (m_left == 0) begin
                model_commit();
                m_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("req_ready", 64'(req_ready), 64'(!m_pend));
            chk("resp_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_error", 64'(resp_error), 64'(m_err));
            end
        end
    end

    task automatic access(input logic w, input logic [1:0] sz, input logic sg, input int a,
                          input logic [63:0] wd, output logic [63:0] rd, output logic er);
        int g;
        req_write = w; req_size = sz; req_signed = sg; req_address = 11'(a); req_wdata = wd;
        req_valid = 1'b1; resp_ready = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (!resp_valid && g < 50) begin @(posedge clk); #1; g++; end
        chk("no_timeout", 64'(g < 50), 64'd1);
        rd = resp_rdata; er = resp_error;
        @(posedge clk); #1;
    endtask

    task automatic lit(input string nm, input logic [63:0] rd, input logic er,
                       input logic [63:0] erd, input logic eer);
        chk({nm, "_data"}, rd, erd);
        chk({nm, "_err"}, 64'(er), 64'(eer));
    endtask

    logic [63:0] rd;
    logic        er;

    initial begin
        int g;
        for (int i = 0; i < 2048; i++) m_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_error", 64'(resp_error), 64'd0);
        rst_n = 1'b1;
        m_on = 1'b1;
        @(posedge clk); #1;

        access(1, 2'd3, 0, 'h010, 64'h0123456789ABCDEF, rd, er); lit("st_d", rd, er, 0, 0);
        access(0, 2'd3, 0, 'h010, 0, rd, er); lit("ld_d", rd, er, 64'h0123456789ABCDEF, 0);
        access(0, 2'd0, 0, 'h010, 0, rd, er); lit("ld_b10", rd, er, 64'h01, 0);
        access(0, 2'd0, 0, 'h017, 0, rd, er); lit("ld_b17", rd, er, 64'hEF, 0);
        access(0, 2'd2, 1, 'h014, 0, rd, er); lit("ld_w14s", rd, er, 64'hFFFFFFFF89ABCDEF, 0);

        access(1, 2'd0, 0, 'h020, 64'hFFFF_FF80, rd, er); lit("st_b80", rd, er, 0, 0);
        access(0, 2'd0, 1, 'h020, 0, rd, er); lit("ld_bs", rd, er, 64'hFFFFFFFFFFFFFF80, 0);
        access(0, 2'd0, 0, 'h020, 0, rd, er); lit("ld_bu", rd, er, 64'h80, 0);
        access(1, 2'd1, 0, 'h022, 64'h7FFF, rd, er); lit("st_h", rd, er, 0, 0);
        access(0, 2'd1, 1, 'h022, 0, rd, er); lit("ld_hs", rd, er, 64'h7FFF, 0);
        access(0, 2'd1, 1, 'h020, 0, rd, er); lit("ld_h20s", rd, er, 64'hFFFFFFFFFFFF8000, 0);
        access(0, 2'd2, 1, 'h020, 0, rd, er); lit("ld_w20s", rd, er, 64'hFFFFFFFF80007FFF, 0);

        access(1, 2'd0, 0, 'h7FE, 64'h5A, rd, er); lit("st_b7fe", rd, er, 0, 0);
        access(0, 2'd2, 0, 'h7FC, 0, rd, er); lit("ld_w7fc", rd, er, 64'h5A00, 0);
        access(0, 2'd3, 0, 'h7F8, 0, rd, er); lit("ld_d7f8", rd, er, 64'h5A00, 0);
        access(1, 2'd2, 0, 'h7FE, 64'h11223344, rd, er); lit("st_w7fe", rd, er, 0, 1);
        access(0, 2'd0, 0, 'h7FE, 0, rd, er); lit("ld_b7fe", rd, er, 64'h5A, 0);
        access(0, 2'd3, 0, 'h7F9, 0, rd, er); lit("ld_d7f9", rd, er, 0, 1);

        // held response with back-pressure, plus ignored requests while busy
        req_write = 0; req_size = 2'd3; req_signed = 0; req_address = 11'h010; req_valid = 1; resp_ready = 0;
        @(posedge clk); #1;
        for (int i = 0; i < LAT - 1; i++) begin
            req_write = 1; req_size = 2'd0; req_address = 11'h040; req_wdata = 64'h55;
            chk("busy_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        req_valid = 0;
        g = 0;
        while (!resp_valid && g < 20) begin @(posedge clk); #1; g++; end
        chk("hold_arrive", 64'(resp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_data", resp_rdata, 64'h0123456789ABCDEF);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        chk("hold_release", 64'(resp_valid), 64'd0);
        access(0, 2'd0, 0, 'h040, 0, rd, er); lit("ld_b40", rd, er, 0, 0);

        // misaligned word store
        access(1, 2'd2, 0, 'h006, 64'hDEADBEEF, rd, er);
`ifdef MISALIGN_TRAP_EN
        lit("st_w006", rd, er, 0, 1);
        access(0, 2'd0, 0, 'h006, 0, rd, er); lit("ld_b006", rd, er, 0, 0);
`else
        lit("st_w006", rd, er, 0, 0);
        access(0, 2'd2, 0, 'h006, 0, rd, er); lit("ld_w006", rd, er, 64'hDEADBEEF, 0);
`endif

        // reset during BUSY abandons an uncommitted store
        req_write = 1; req_size = 2'd0; req_signed = 0; req_address = 11'h030; req_wdata = 64'hAA; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        rst_n = 0;
        #1;
        chk("abort_valid", 64'(resp_valid), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        chk("post_rst_valid", 64'(resp_valid), 64'd0);
        access(0, 2'd0, 0, 'h030, 0, rd, er); lit("ld_b30", rd, er, 0, 0);
        access(0, 2'd3, 0, 'h010, 0, rd, er); lit("ld_d_after_rst", rd, er, 64'h0123456789ABCDEF, 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
